// File: rtl/uart_mmio_if.sv
// Core data-bus port bundle for the uart_mmio peripheral.
interface uart_mmio_if;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        memwrite;
   logic        memread;
   logic        sel;

   modport master (output adr, output writedata, output memwrite, output memread,
                   input readdata, input sel);
   modport slave  (input adr, input writedata, input memwrite, input memread,
                   output readdata, output sel);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped UART: DATA/STATUS word registers, TX/RX byte FIFOs, 8N1 serial engines.
// Optional feature: define UART_MMIO_LOOPBACK_EN for the STATUS[8] internal loopback control.
module uart_mmio #(
   parameter int unsigned CLK_PER_HALF_BIT = 434,
   parameter int unsigned FIFO_DEPTH_LOG2  = 4,
   parameter logic [31:0] BASE_ADDR        = 32'h0000_3000
) (
   input  logic       clk,
   input  logic       rstn,
   uart_mmio_if.slave bus,
   output logic       txd,
   input  logic       rxd
);

   localparam int unsigned AW        = FIFO_DEPTH_LOG2;
   localparam int unsigned PW        = AW + 1;
   localparam int unsigned DEPTH     = 1 << AW;
   localparam int unsigned BIT_CYC   = 2 * CLK_PER_HALF_BIT;
   localparam int unsigned CNT_W     = $clog2(BIT_CYC);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // Bus decode; a simultaneous write suppresses the read
   logic w_sel, w_wr, w_rd, w_wr_data, w_wr_stat, w_rd_data, w_rd_stat;
   assign w_sel     = (bus.adr[31:3] == BASE_ADDR[31:3]);
   assign bus.sel   = w_sel;
   assign w_wr      = w_sel & bus.memwrite;
   assign w_rd      = w_sel & bus.memread & ~bus.memwrite;
   assign w_wr_data = w_wr & ~bus.adr[2];
   assign w_wr_stat = w_wr &  bus.adr[2];
   assign w_rd_data = w_rd & ~bus.adr[2];
   assign w_rd_stat = w_rd &  bus.adr[2];

   logic w_unused;
   assign w_unused = &{1'b0, bus.adr[1:0], bus.writedata[31:8], w_wr_stat};

   // TX FIFO
   logic [7:0]    r_tx_mem [DEPTH];
   logic [PW-1:0] r_tx_wp, r_tx_rp;
   logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
   logic [7:0]    w_tx_head;

   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
   assign w_tx_push  = w_wr_data & (~w_tx_full | w_tx_pop);
   assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.writedata[7:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tx_wp <= '0;
         r_tx_rp <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
      end
   end

   // TX engine
   state_t           r_tx_state, w_tx_state_nxt;
   logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
   logic [2:0]       r_tx_bit, w_tx_bit_nxt;
   logic [7:0]       r_tx_shift, w_tx_shift_nxt;
   logic             r_txd, w_txd_nxt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_txd      <= w_txd_nxt;
      end
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_shift_nxt = r_tx_shift;
      w_txd_nxt      = r_txd;
      w_tx_pop       = 1'b0;
      unique case (r_tx_state)
         S_IDLE: begin
            w_tx_cnt_nxt = '0;
            if (!w_tx_empty) begin
               w_tx_pop       = 1'b1;
               w_tx_state_nxt = S_START;
               w_tx_shift_nxt = w_tx_head;
               w_txd_nxt      = 1'b0;
            end
         end
         S_START: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_nxt   = '0;
               w_tx_bit_nxt   = '0;
               w_tx_state_nxt = S_DATA;
               w_txd_nxt      = r_tx_shift[0];
            end
         end
         S_DATA: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_nxt = '0;
               if (r_tx_bit == 3'd7) begin
                  w_tx_state_nxt = S_STOP;
                  w_txd_nxt      = 1'b1;
               end else begin
                  w_tx_bit_nxt   = r_tx_bit + 3'd1;
                  w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                  w_txd_nxt      = r_tx_shift[1];
               end
            end
         end
         S_STOP: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_nxt = '0;
               // Back-to-back frames skip IDLE entirely
               if (!w_tx_empty) begin
                  w_tx_pop       = 1'b1;
                  w_tx_state_nxt = S_START;
                  w_tx_shift_nxt = w_tx_head;
                  w_txd_nxt      = 1'b0;
               end else begin
                  w_tx_state_nxt = S_IDLE;
               end
            end
         end
         default: w_tx_state_nxt = S_IDLE;
      endcase
   end

   // Loopback control and serial line muxing
   logic w_rx_in;
`ifdef UART_MMIO_LOOPBACK_EN
   logic r_loop;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          r_loop <= 1'b0;
      else if (w_wr_stat) r_loop <= bus.writedata[8];
   end
   assign w_rx_in = r_loop ? r_txd : rxd;
   assign txd     = r_txd | r_loop;
`else
   assign w_rx_in = rxd;
   assign txd     = r_txd;
`endif

   // RX synchroniser and falling-edge detect
   logic [1:0] r_rx_sync;
   logic       r_rx_prev, w_rx_s, w_rx_fall;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rx_sync <= 2'b11;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_sync <= {r_rx_sync[0], w_rx_in};
         r_rx_prev <= r_rx_sync[1];
      end
   end
   assign w_rx_s    = r_rx_sync[1];
   assign w_rx_fall = r_rx_prev & ~w_rx_s;

   // RX engine
   state_t           r_rx_state, w_rx_state_nxt;
   logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]       r_rx_bit, w_rx_bit_nxt;
   logic [7:0]       r_rx_shift, w_rx_shift_nxt;
   logic             w_rx_ok, w_rx_ferr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_ok        = 1'b0;
      w_rx_ferr      = 1'b0;
      unique case (r_rx_state)
         S_IDLE: begin
            w_rx_cnt_nxt = '0;
            if (w_rx_fall) w_rx_state_nxt = S_START;
         end
         S_START: begin
            // Mid-start-bit re-sample rejects glitches
            if (r_rx_cnt == HALF_LAST) begin
               w_rx_cnt_nxt   = '0;
               w_rx_bit_nxt   = '0;
               w_rx_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_rx_cnt == BIT_LAST) begin
               w_rx_cnt_nxt   = '0;
               w_rx_shift_nxt = {w_rx_s, r_rx_shift[7:1]};
               if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
               else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
            end
         end
         S_STOP: begin
            if (r_rx_cnt == BIT_LAST) begin
               w_rx_cnt_nxt   = '0;
               w_rx_state_nxt = S_IDLE;
               w_rx_ok        = w_rx_s;
               w_rx_ferr      = ~w_rx_s;
            end
         end
         default: w_rx_state_nxt = S_IDLE;
      endcase
   end

   // RX FIFO
   logic [7:0]    r_rx_mem [DEPTH];
   logic [PW-1:0] r_rx_wp, r_rx_rp;
   logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_ovr_set;
   logic [7:0]    w_rx_head;

   assign w_rx_empty = (r_rx_wp == r_rx_rp);
   assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
   assign w_rx_pop   = w_rd_data & ~w_rx_empty;
   assign w_rx_push  = w_rx_ok & (~w_rx_full | w_rx_pop);
   assign w_ovr_set  = w_rx_ok & w_rx_full & ~w_rx_pop;
   assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rx_wp <= '0;
         r_rx_rp <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
      end
   end

   // Sticky error flags; a new event in the clearing cycle is kept
   logic r_ovr, r_ferr;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_ovr  <= w_ovr_set | (r_ovr  & ~w_rd_stat);
         r_ferr <= w_rx_ferr | (r_ferr & ~w_rd_stat);
      end
   end

   // Read path
   logic [31:0] w_status, r_readdata;
   always_comb begin
      w_status    = '0;
      w_status[0] = ~w_rx_empty;
      w_status[1] = w_tx_full;
      w_status[2] = r_ovr;
      w_status[3] = r_ferr;
      w_status[4] = w_tx_empty & (r_tx_state == S_IDLE);
`ifdef UART_MMIO_LOOPBACK_EN
      w_status[8] = r_loop;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_readdata <= '0;
      end else if (w_rd_stat) begin
         r_readdata <= w_status;
      end else if (w_rd_data) begin
         r_readdata <= w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      end
   end
   assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with read/TX scoreboards; small baud and depth-4 FIFOs.
module tb_uart_mmio;
   localparam logic [31:0] BASE   = 32'h0000_3000;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'd4;
   localparam logic [31:0] A_NOSEL = 32'h0000_4000;

   logic clk, rstn, txd, rxd;
   uart_mmio_if bus ();

   uart_mmio #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH_LOG2(2), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .txd(txd), .rxd(rxd));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned rst_epoch = 0;
   logic [31:0] rd_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] last_rd = 32'd0;
   logic        chk_b2b = 1'b0;
   logic        mon_have_prev = 1'b0;
   int unsigned mon_last_st = 0;

   always @(posedge clk) cyc <= cyc + 1;
   initial forever begin
      @(negedge rstn);
      rst_epoch++;
   end

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.adr = a; bus.writedata = d; bus.memwrite = 1'b1;
      @(negedge clk);
      bus.memwrite = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      rd_q.push_back(exp);
      bus.adr = a; bus.memread = 1'b1;
      @(negedge clk);
      bus.memread = 1'b0;
      e = rd_q.pop_front();
      check(bus.readdata, e, tag);
      last_rd = e;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = f[i];
         repeat (8) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   // TX line monitor: decodes frames mid-bit and checks them against tx_q
   initial begin : tx_mon
      logic [9:0]  fr;
      logic [7:0]  eb;
      int unsigned st, ep;
      logic        aborted;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && txd === 1'b0) begin
            st = cyc; ep = rst_epoch; aborted = 1'b0; fr = '0;
            for (int k = 0; k < 10; k++) begin
               repeat ((k == 0) ? 4 : 8) @(negedge clk);
               if (ep != rst_epoch) begin aborted = 1'b1; break; end
               fr[k] = txd;
            end
            if (!aborted) begin
               if (tx_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $error("FAIL tx_unexpected: observed frame=%h expected no frame", fr);
               end else begin
                  eb = tx_q.pop_front();
                  check({22'd0, fr}, {22'd0, 1'b1, eb, 1'b0}, "tx_frame");
               end
               if (chk_b2b && mon_have_prev) check(st - mon_last_st, 32'd80, "tx_gap");
               mon_have_prev = 1'b1;
               mon_last_st   = st;
            end else begin
               mon_have_prev = 1'b0;
            end
         end
      end
   end

   initial begin : main
      logic any_low;
      rstn = 1'b0; rxd = 1'b1;
      bus.adr = '0; bus.writedata = '0; bus.memwrite = 1'b0; bus.memread = 1'b0;
      repeat (3) @(negedge clk);
      check({31'd0, txd}, 32'd1, "rst_txd");
      check(bus.readdata, 32'd0, "rst_readdata");
      rstn = 1'b1;
      @(negedge clk);
      bus_read(A_STAT, 32'h10, "rst_status");

      // Decode and unselected-access isolation
      bus.adr = A_NOSEL;
      #1 check({31'd0, bus.sel}, 32'd0, "sel_low");
      bus.adr = A_STAT;
      #1 check({31'd0, bus.sel}, 32'd1, "sel_high");
      @(negedge clk);
      bus.adr = A_NOSEL; bus.memread = 1'b1;
      @(negedge clk);
      bus.memread = 1'b0;
      check(bus.readdata, last_rd, "nosel_read_hold");
      bus_write(A_NOSEL, 32'h77);

      // TX 0x5A: txd falls two edges after the write
      tx_q.push_back(8'h5A);
      bus_write(A_DATA, 32'h5A);
      check({31'd0, txd}, 32'd1, "tx_not_yet");
      @(negedge clk);
      check({31'd0, txd}, 32'd0, "tx_fall_lat");
      repeat (82) @(negedge clk);
      bus_read(A_STAT, 32'h10, "tx_idle_after");

      // RX 0xA5
      send_rx(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, 32'h11, "rx_status_valid");
      bus_read(A_DATA, 32'hA5, "rx_data");
      bus_read(A_STAT, 32'h10, "rx_status_empty");

      // RX overrun with a 4-deep FIFO
      for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, 32'h15, "ovr_status");
      for (int i = 1; i <= 4; i++) bus_read(A_DATA, 32'(i), "ovr_data");
      bus_read(A_DATA, 32'h0, "rx_empty_read");
      bus_read(A_STAT, 32'h10, "ovr_cleared");

      // Framing error, then a short glitch
      send_rx(8'h33, 1'b0);
      repeat (4) @(negedge clk);
      bus_read(A_STAT, 32'h18, "frame_err");
      bus_read(A_STAT, 32'h10, "frame_err_clr");
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      bus_read(A_STAT, 32'h10, "glitch_ignored");

`ifndef UART_MMIO_LOOPBACK_EN
      bus_write(A_STAT, 32'h1FF);
      bus_read(A_STAT, 32'h10, "status_wr_ignored");
`endif

      // Five back-to-back TX bytes into a 4-deep FIFO
      mon_have_prev = 1'b0;
      chk_b2b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_q.push_back(8'(8'h11 * (i + 1)));
         bus_write(A_DATA, 32'(8'h11 * (i + 1)));
      end
      bus_read(A_STAT, 32'h02, "tx_full");
      repeat (410) @(negedge clk);
      check(32'(tx_q.size()), 32'd0, "tx_all_sent");
      bus_read(A_STAT, 32'h10, "tx_b2b_idle");
      chk_b2b = 1'b0;

      // Asynchronous reset mid-frame
      tx_q.push_back(8'h00);
      bus_write(A_DATA, 32'h00);
      repeat (20) @(negedge clk);
      check({31'd0, txd}, 32'd0, "tx_mid_frame");
      #2 rstn = 1'b0;
      #1 check({31'd0, txd}, 32'd1, "txd_async_rst");
      check(bus.readdata, 32'd0, "readdata_async_rst");
      @(negedge clk);
      rstn = 1'b1;
      tx_q.delete();
      @(negedge clk);
      bus_read(A_STAT, 32'h10, "status_after_rst");

`ifdef UART_MMIO_LOOPBACK_EN
      bus_write(A_STAT, 32'h100);
      bus_read(A_STAT, 32'h110, "loop_enabled");
      bus_write(A_DATA, 32'h3C);
      any_low = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) any_low = 1'b1;
      end
      check({31'd0, any_low}, 32'd0, "loop_txd_high");
      bus_read(A_DATA, 32'h3C, "loop_data");
`else
      any_low = 1'b0;
`endif

      repeat (5) @(negedge clk);
      check(32'(tx_q.size()), 32'd0, "tx_q_drained");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
